// File: rtl/rr_reg_write_arbiter.sv
// rr_reg_write_arbiter: round-robin write sequencer for one shared register with a fixed cool-down between writes
module rr_reg_write_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int HOLD  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       q,
   output logic                   q_valid,
   output logic                   busy
);
   localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
   typedef enum logic [1:0] {IDLE, WRITE, COOL} state_t;
   state_t state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic q_valid_q, q_valid_d;
   logic [PW-1:0] ptr_q, ptr_d, sel_q, sel_d, pick;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d   = state_q;
      gnt_d     = '0;
      ack_d     = '0;
      q_d       = q_q;
      q_valid_d = q_valid_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      pick      = ptr_q;
      // scanning from lowest priority upward lets the nearest-to-ptr requester win
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req[PW'((int'(ptr_q) + i) % N_REQ)]) pick = PW'((int'(ptr_q) + i) % N_REQ);
      case (state_q)
         IDLE: if (|req) begin
            state_d = WRITE;
            sel_d   = pick;
            gnt_d   = N_REQ'(1) << pick;
         end
         WRITE: begin
            if (req[sel_q]) begin
               q_d       = wdata[sel_q*WIDTH +: WIDTH];
               q_valid_d = 1'b1;
               ack_d     = N_REQ'(1) << sel_q;
            end
            ptr_d   = PW'((int'(sel_q) + 1) % N_REQ);
            state_d = HOLD > 0 ? COOL : IDLE;
            cnt_d   = CW'(HOLD > 0 ? HOLD - 1 : 0);
         end
         COOL: begin
            state_d = cnt_q == '0 ? IDLE : COOL;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         ack_q     <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
         ptr_q     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
      end
   end
   assign gnt     = gnt_q;
   assign ack     = ack_q;
   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// tb_rr_reg_write_arbiter: directed scenario checks for the round-robin register write arbiter
module tb_rr_reg_write_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [3:0] req = '0;
   logic [31:0] wdata = '0;
   logic [3:0] gnt, ack;
   logic [7:0] q;
   logic q_valid, busy;
   int total = 0;
   int bad = 0;

   rr_reg_write_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(2)) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata),
      .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task tick;
      @(posedge clk);
      #1;
   endtask

   task do_reset;
      rst = 1'b0;
      req = '0;
      tick;
      rst = 1'b1;
   endtask

   task test_reset;
      rst = 1'b0;
      req = 4'b1111;
      wdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 2; k++) begin
         tick;
         total++;
         if ({gnt, ack, q, q_valid, busy} !== 18'h0) begin
            bad++;
            $display("FAIL reset_hold%0d gnt=%b ack=%b q=%h qv=%b busy=%b exp all zero", k, gnt, ack, q, q_valid, busy);
         end
      end
      rst = 1'b1;
      tick;
      total++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_release gnt=%b busy=%b exp gnt=0001 busy=1", gnt, busy);
      end
      rst = 1'b0;
      #3;
      total++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_midcycle gnt=%b busy=%b exp unchanged gnt=0001 busy=1", gnt, busy);
      end
      tick;
      total++;
      if ({gnt, ack, q, q_valid, busy} !== 18'h0) begin
         bad++;
         $display("FAIL reset_edge gnt=%b ack=%b q=%h qv=%b busy=%b exp all zero", gnt, ack, q, q_valid, busy);
      end
      req = '0;
      rst = 1'b1;
   endtask

   task test_single;
      wdata = {8'h44, 8'hA5, 8'h22, 8'h11};
      req = 4'b0100;
      tick;
      total++;
      if (gnt !== 4'b0100 || ack !== 4'b0000 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_gnt gnt=%b ack=%b busy=%b exp gnt=0100 ack=0000 busy=1", gnt, ack, busy);
      end
      tick;
      total++;
      if (ack !== 4'b0100 || gnt !== 4'b0000 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_ack ack=%b gnt=%b busy=%b exp ack=0100 gnt=0000 busy=1", ack, gnt, busy);
      end
      total++;
      if (q !== 8'hA5 || q_valid !== 1'b1) begin
         bad++;
         $display("FAIL single_q q=%h qv=%b exp q=a5 qv=1", q, q_valid);
      end
      req = '0;
      tick;
      total++;
      if (busy !== 1'b1 || ack !== 4'b0000) begin
         bad++;
         $display("FAIL single_cool busy=%b ack=%b exp busy=1 ack=0000", busy, ack);
      end
      tick;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL single_idle busy=%b exp 0", busy);
      end
   endtask

   task test_round_robin;
      logic [7:0] exp_q;
      do_reset;
      wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         exp_q = wdata[8*k +: 8];
         tick;
         total++;
         if (gnt !== 4'(1 << k)) begin
            bad++;
            $display("FAIL rr_gnt%0d gnt=%b exp=%b", k, gnt, 4'(1 << k));
         end
         tick;
         total++;
         if (ack !== 4'(1 << k) || gnt !== 4'b0000 || q !== exp_q) begin
            bad++;
            $display("FAIL rr_ack%0d ack=%b gnt=%b q=%h exp ack=%b gnt=0000 q=%h", k, ack, gnt, q, 4'(1 << k), exp_q);
         end
         req[k] = 1'b0;
         tick;
         total++;
         if (ack !== 4'b0000) begin
            bad++;
            $display("FAIL rr_noack%0d ack=%b exp 0000", k, ack);
         end
         tick;
         total++;
         if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_idle%0d busy=%b exp 0", k, busy);
         end
      end
   endtask

   task test_wrap;
      req = 4'b0010;
      tick;
      total++;
      if (gnt !== 4'b0010) begin
         bad++;
         $display("FAIL wrap_first gnt=%b exp 0010", gnt);
      end
      tick;
      req = 4'b0011;
      tick;
      tick;
      tick;
      total++;
      if (gnt !== 4'b0001) begin
         bad++;
         $display("FAIL wrap_to0 gnt=%b exp 0001", gnt);
      end
      tick;
      req = 4'b0010;
      tick;
      tick;
      tick;
      total++;
      if (gnt !== 4'b0010) begin
         bad++;
         $display("FAIL wrap_to1 gnt=%b exp 0010", gnt);
      end
      tick;
      req = '0;
      tick;
      tick;
   endtask

   task test_withdraw;
      wdata = {8'h00, 8'h3C, 8'h99, 8'h00};
      req = 4'b0100;
      tick;
      tick;
      total++;
      if (q !== 8'h3C || ack !== 4'b0100) begin
         bad++;
         $display("FAIL wd_setup q=%h ack=%b exp q=3c ack=0100", q, ack);
      end
      req = '0;
      tick;
      tick;
      req = 4'b0010;
      tick;
      total++;
      if (gnt !== 4'b0010) begin
         bad++;
         $display("FAIL wd_gnt gnt=%b exp 0010", gnt);
      end
      req = '0;
      tick;
      total++;
      if (ack !== 4'b0000 || q !== 8'h3C || q_valid !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL wd_noack ack=%b q=%h qv=%b busy=%b exp ack=0000 q=3c qv=1 busy=1", ack, q, q_valid, busy);
      end
      tick;
      tick;
      req = 4'b0110;
      tick;
      total++;
      if (gnt !== 4'b0100) begin
         bad++;
         $display("FAIL wd_next gnt=%b exp 0100", gnt);
      end
      tick;
      req = '0;
      tick;
      tick;
   endtask

   task test_reset_mid;
      wdata = {8'h77, 8'h00, 8'h00, 8'h00};
      req = 4'b1000;
      tick;
      total++;
      if (gnt !== 4'b1000) begin
         bad++;
         $display("FAIL rm_gnt gnt=%b exp 1000", gnt);
      end
      tick;
      total++;
      if (q !== 8'h77 || ack !== 4'b1000) begin
         bad++;
         $display("FAIL rm_write q=%h ack=%b exp q=77 ack=1000", q, ack);
      end
      req = '0;
      tick;
      rst = 1'b0;
      tick;
      total++;
      if ({gnt, ack, q, q_valid, busy} !== 18'h0) begin
         bad++;
         $display("FAIL rm_abort gnt=%b ack=%b q=%h qv=%b busy=%b exp all zero", gnt, ack, q, q_valid, busy);
      end
      rst = 1'b1;
      req = 4'b1001;
      wdata = {8'h88, 8'h00, 8'h00, 8'h66};
      tick;
      total++;
      if (gnt !== 4'b0001) begin
         bad++;
         $display("FAIL rm_ptr0 gnt=%b exp 0001", gnt);
      end
      tick;
      total++;
      if (ack !== 4'b0001 || q !== 8'h66 || q_valid !== 1'b1) begin
         bad++;
         $display("FAIL rm_ack0 ack=%b q=%h qv=%b exp ack=0001 q=66 qv=1", ack, q, q_valid);
      end
      req = 4'b1000;
      tick;
      tick;
      tick;
      total++;
      if (gnt !== 4'b1000) begin
         bad++;
         $display("FAIL rm_gnt3 gnt=%b exp 1000", gnt);
      end
      tick;
      total++;
      if (ack !== 4'b1000 || q !== 8'h88) begin
         bad++;
         $display("FAIL rm_ack3 ack=%b q=%h exp ack=1000 q=88", ack, q);
      end
      req = '0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_wrap;
      test_withdraw;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
